// File: rtl/dec_ptv_ctrl_if.sv
// Request/response/config/decoder bundle for dec_ptv_ctrl; slave is the controller view.
// Latency and backpressure are defined by the controller; this file only groups the signals.
interface dec_ptv_ctrl_if #(
  parameter int BITMAP = 128,
  parameter int REQS   = 4
);
  localparam int ADDR_W = $clog2(BITMAP);
  localparam int STAGES = ADDR_W;
  localparam int NODES  = BITMAP / 2;
  localparam int ID_W   = $clog2(REQS);
  localparam int SEL_W  = $clog2(STAGES);

  logic [REQS-1:0]                 i_req_valid;
  logic [REQS-1:0][ADDR_W-1:0]     i_req_paddr;
  logic [REQS-1:0]                 o_req_ready;

  logic                            o_rsp_valid;
  logic [ID_W-1:0]                 o_rsp_id;
  logic [ADDR_W-1:0]               o_rsp_vaddr;
  logic                            i_rsp_ready;

  logic                            i_cfg_valid;
  logic [SEL_W-1:0]                i_cfg_stage;
  logic [NODES-1:0]                i_cfg_scb;
  logic                            o_cfg_ready;

  logic [ADDR_W-1:0]               o_dec_paddr;
  logic                            o_dec_oreg_en;
  logic [STAGES-1:0][NODES-1:0]    o_dec_scb;
  logic [ADDR_W-1:0]               i_dec_vaddr;

  modport slave (
    input  i_req_valid, i_req_paddr, i_rsp_ready, i_cfg_valid, i_cfg_stage, i_cfg_scb, i_dec_vaddr,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_vaddr, o_cfg_ready, o_dec_paddr, o_dec_oreg_en,
           o_dec_scb
  );

  modport master (
    output i_req_valid, i_req_paddr, i_rsp_ready, i_cfg_valid, i_cfg_stage, i_cfg_scb, i_dec_vaddr,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_vaddr, o_cfg_ready, o_dec_paddr, o_dec_oreg_en,
           o_dec_scb
  );
endinterface

// File: rtl/dec_ptv_ctrl.sv
// Round-robin translation controller in front of a PTV decoder; owns the SCB bank, one translation in flight.
// Accept-to-response 2 cycles, 3 cycles per translation; response held until i_rsp_ready, config only taken in IDLE.
module dec_ptv_ctrl #(
  parameter int BITMAP = 128,
  parameter int REQS   = 4
) (
  input logic          i_clk,
  input logic          i_rst_n,
  dec_ptv_ctrl_if.slave bus
);
  localparam int ADDR_W = $clog2(BITMAP);
  localparam int STAGES = ADDR_W;
  localparam int NODES  = BITMAP / 2;
  localparam int ID_W   = $clog2(REQS);
  localparam int SEL_W  = $clog2(STAGES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [ID_W-1:0]              rr_ptr_q;
  logic [ID_W-1:0]              cap_id_q;
  logic [ADDR_W-1:0]            cap_paddr_q;
  logic [STAGES-1:0][NODES-1:0] scb_q;

  logic                         grant_vld;
  logic [ID_W-1:0]              grant_id;
  logic                         cfg_fire;
  logic                         req_fire;
  logic                         rsp_fire;
  logic                         cfg_row_ok;

  // Scan downward in offset so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = REQS - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(rr_ptr_q) + i) % REQS;
      if (bus.i_req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  assign cfg_fire   = (state_q == S_IDLE) && bus.i_cfg_valid;
  assign req_fire   = (state_q == S_IDLE) && !bus.i_cfg_valid && grant_vld;
  assign rsp_fire   = (state_q == S_RESP) && bus.i_rsp_ready;
  assign cfg_row_ok = (int'(bus.i_cfg_stage) < STAGES);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_fire) state_d = S_ISSUE;
      S_ISSUE: state_d = S_RESP;
      S_RESP:  if (bus.i_rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake readies are gated by reset so nothing is accepted while held in reset.
  always_comb begin
    bus.o_req_ready = '0;
    if (req_fire && i_rst_n) begin
      bus.o_req_ready[grant_id] = 1'b1;
    end
    bus.o_cfg_ready   = cfg_fire && i_rst_n;
    bus.o_rsp_valid   = (state_q == S_RESP);
    bus.o_rsp_id      = cap_id_q;
    bus.o_rsp_vaddr   = bus.i_dec_vaddr;
    bus.o_dec_oreg_en = (state_q == S_ISSUE);
    bus.o_dec_paddr   = cap_paddr_q;
    bus.o_dec_scb     = scb_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q    <= '0;
      cap_id_q    <= '0;
      cap_paddr_q <= '0;
      scb_q       <= '0;
    end else begin
      if (cfg_fire && cfg_row_ok) begin
        scb_q[bus.i_cfg_stage] <= bus.i_cfg_scb;
      end
      if (req_fire) begin
        cap_paddr_q <= bus.i_req_paddr[grant_id];
        cap_id_q    <= grant_id;
      end
      if (rsp_fire) begin
        rr_ptr_q <= (cap_id_q == ID_W'(REQS - 1)) ? '0 : cap_id_q + ID_W'(1);
      end
    end
  end
endmodule

// File: doc/dec_ptv_ctrl.md
DEC_PTV_CTRL -- requirements
Module: dec_ptv_ctrl

Interface
REQ-001 Parameter BITMAP, default 128: bitmap size served by the attached decoder; ADDR_W=STAGES=clog2(BITMAP), NODES=BITMAP/2 (localparams).
REQ-002 Parameter REQS, default 4: number of translation requesters, >=2; ID_W=clog2(REQS), SEL_W=clog2(STAGES) (localparams).
REQ-003 i_clk  in  1  sole clock, all state on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_req_valid  in  [REQS]  per-requester translation request.
REQ-006 i_req_paddr  in  [REQS][ADDR_W]  per-requester physical address.
REQ-007 o_req_ready  out  [REQS]  one-hot accept strobe; transfer when valid&ready.
REQ-008 o_rsp_valid  out  1  response available.
REQ-009 o_rsp_id  out  ID_W  index of requester owning the response.
REQ-010 o_rsp_vaddr  out  ADDR_W  translated virtual address.
REQ-011 i_rsp_ready  in  1  response consumer ready.
REQ-012 i_cfg_valid  in  1  SCB row write request.
REQ-013 i_cfg_stage  in  SEL_W  target stage row.
REQ-014 i_cfg_scb  in  NODES  new switch-control bits for that row.
REQ-015 o_cfg_ready  out  1  config write accepted when valid&ready.
REQ-016 o_dec_paddr  out  ADDR_W  physical address driven to decoder.
REQ-017 o_dec_oreg_en  out  1  decoder output-register enable.
REQ-018 o_dec_scb  out  [STAGES][NODES]  SCB bank driven to decoder.
REQ-019 i_dec_vaddr  in  ADDR_W  decoder registered virtual address.

Function
REQ-020 FSM states IDLE, ISSUE, RESP; one-hot or binary encoding is implementer's choice.
REQ-021 IDLE, i_cfg_valid=1: o_cfg_ready=1, all o_req_ready=0; row i_cfg_stage of SCB bank written at that edge; stay IDLE (config has priority over requests).
REQ-022 Config write with i_cfg_stage>=STAGES: handshake completes, bank unchanged.
REQ-023 o_cfg_ready=0 in ISSUE and RESP; SCB bank never changes while a translation is in flight.
REQ-024 IDLE, i_cfg_valid=0, any i_req_valid: round-robin grant g = first valid index at or after pointer rr_ptr (wrapping); o_req_ready[g]=1 combinationally that cycle only; paddr and g captured; next state ISSUE.
REQ-025 ISSUE: o_dec_oreg_en=1 for exactly one cycle, o_dec_paddr=captured paddr; next state RESP.
REQ-026 RESP: o_rsp_valid=1, o_rsp_id=g, o_rsp_vaddr=i_dec_vaddr; hold until i_rsp_ready=1, then rr_ptr<=(g+1) mod REQS, next state IDLE.
REQ-027 o_dec_oreg_en=0 in every state other than ISSUE; o_dec_paddr holds last captured value outside ISSUE.
REQ-028 Latency: request accepted at edge T -> o_rsp_valid high in cycle T+2; minimum 3 cycles per translation (no pipelining).
REQ-029 Response outputs stable while o_rsp_valid=1 and i_rsp_ready=0.
REQ-030 rr_ptr advances only on response completion; an unserved requester waits at most REQS-1 translations once config traffic stops.
REQ-031 o_req_ready is all-zero whenever state!=IDLE or i_cfg_valid=1.

Reset
REQ-032 i_rst_n=0 asynchronously: state IDLE, rr_ptr=0, SCB bank all zeros, captured paddr/id 0; o_rsp_valid=0, o_rsp_id=0, o_dec_oreg_en=0, o_dec_paddr=0, o_req_ready=0, o_cfg_ready=0 (while in reset).
REQ-033 Reset during ISSUE or RESP drops the in-flight translation; no response issued after release.
REQ-034 First accept possible in first cycle with i_rst_n=1 sampled high.

Verification (BITMAP=8, REQS=4)
REQ-035 Reset then single request r2, paddr=3'd5, SCB all zero -> o_req_ready=4'b0100 one cycle, oreg_en pulse next cycle, rsp_valid 2 cycles after accept, id=2, vaddr=decoder output for paddr 5.
REQ-036 All four valid continuously, i_rsp_ready=1 -> grant order 0,1,2,3,0; one response every 3 cycles.
REQ-037 i_cfg_valid and i_req_valid[0] same IDLE cycle, stage=1, scb=4'hA -> cfg accepted, o_dec_scb[1]=4'hA next cycle, request accepted the following cycle.
REQ-038 i_rsp_ready=0 for 5 cycles in RESP -> rsp outputs constant, oreg_en stays 0, cfg_ready and req_ready stay 0.
REQ-039 Config with stage=3 (>=STAGES) -> handshake once, o_dec_scb unchanged.
REQ-040 Assert i_rst_n=0 mid-RESP -> o_rsp_valid falls immediately, SCB bank zero, no response after release.
